// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared definitions for the memory-access stage: funct3 access-size codes
// and the bus FSM state encoding.
package mem_stage_lsu_pkg;

    // funct3 access size / signedness codes
    localparam logic [2:0] LSU_B  = 3'd0;   // signed byte
    localparam logic [2:0] LSU_H  = 3'd1;   // signed half
    localparam logic [2:0] LSU_W  = 3'd2;   // word
    localparam logic [2:0] LSU_BU = 3'd4;   // unsigned byte
    localparam logic [2:0] LSU_HU = 3'd5;   // unsigned half

    // Bus FSM: IDLE waits for a legal access, REQ holds the bus until memAck
    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_REQ  = 1'b1
    } lsuState_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align
// Purely combinational lane logic for the memory stage.
//   addrLow    in   2  effective address bits [1:0]
//   funct3     in   3  access size / sign code
//   storeData  in  32  raw store operand (rs2)
//   readData   in  32  word returned by the bus
//   byteEn     out  4  byte enables for the access
//   storeWord  out 32  store data replicated across lanes
//   loadData   out 32  selected and extended load value
//   misaligned out  1  half on odd address or word not 4-aligned
//   illegal    out  1  funct3 is not a defined size code
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  addrLow,
    input  logic [2:0]  funct3,
    input  logic [31:0] storeData,
    input  logic [31:0] readData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord,
    output logic [31:0] loadData,
    output logic        misaligned,
    output logic        illegal
);

    logic        isByte;
    logic        isHalf;
    logic        isWord;
    logic [31:0] shifted;

    always_comb begin
        isByte     = (funct3 == LSU_B) || (funct3 == LSU_BU);
        isHalf     = (funct3 == LSU_H) || (funct3 == LSU_HU);
        isWord     = (funct3 == LSU_W);
        illegal    = !(isByte || isHalf || isWord);
        misaligned = (isHalf && addrLow[0]) || (isWord && (addrLow != 2'b00));
    end

    // Per-lane enable and store data: bytes replicate into every lane, halves
    // into both half-words, so the bus only needs byte enables to pick lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byteEn[gi] = isWord
                              || (isHalf && (addrLow[1] == 1'(gi / 2)))
                              || (isByte && (addrLow == 2'(gi)));
            assign storeWord[8*gi +: 8] = isWord ? storeData[8*gi +: 8]
                                        : isHalf ? storeData[8*(gi % 2) +: 8]
                                        : storeData[7:0];
        end
    endgenerate

    // Bring the addressed byte/half down to bit 0; words are always aligned
    // here (a misaligned word never reaches the bus), so the shift is zero.
    assign shifted = readData >> {addrLow, 3'b000};

    always_comb begin
        case (funct3)
            LSU_B:   loadData = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  loadData = {24'd0, shifted[7:0]};
            LSU_H:   loadData = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  loadData = {16'd0, shifted[15:0]};
            LSU_W:   loadData = shifted;
            default: loadData = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory-access stage between EX/MEM and MEM/WB. Turns load/store micro-ops
// into a registered req/ack bus transaction, stalls the front of the pipe
// while the access is outstanding and presents the MEM/WB write bundle.
//   clk, rst                 clock, asynchronous active-high reset
//   ex*                      EX/MEM register contents (held while stall = 1)
//   wbALUOutput/wbWriteDir/wbMemToReg   pass-through to MEM/WB
//   wbDataOutput             formatted load data (valid in the ack cycle)
//   wbRegWrite               register write, suppressed on faults
//   stall                    freeze upstream stages; MEM/WB en = !stall
//   memFault                 one-cycle pulse: misaligned, illegal, timeout
//   memReq/memWe/memAddr/memWdata/memBe   registered bus request
//   memAck, memRdata         bus completion and read data
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exValid,
    input  logic [31:0] exALUOutput,
    input  logic [31:0] exStoreData,
    input  logic        exMemRead,
    input  logic        exMemWrite,
    input  logic [2:0]  exFunct3,
    input  logic [4:0]  exWriteDir,
    input  logic        exRegWrite,
    input  logic        exMemToReg,
    output logic [31:0] wbALUOutput,
    output logic [31:0] wbDataOutput,
    output logic [4:0]  wbWriteDir,
    output logic        wbRegWrite,
    output logic        wbMemToReg,
    output logic        stall,
    output logic        memFault,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memAck,
    input  logic [31:0] memRdata
);

    localparam bit              TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value seen in the REQ cycle that exhausts the budget
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsuState_t        stateReg;
    logic [CNT_W-1:0] cntReg;

    logic        access;
    logic        inReq;
    logic        alignFault;
    logic        idleFault;
    logic        startReq;
    logic        ackHit;
    logic        timeoutHit;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic [31:0] alignLoad;
    logic        alignMisaligned;
    logic        alignIllegal;

    lsu_align u_align (
        .addrLow    (exALUOutput[1:0]),
        .funct3     (exFunct3),
        .storeData  (exStoreData),
        .readData   (memRdata),
        .byteEn     (alignBe),
        .storeWord  (alignWdata),
        .loadData   (alignLoad),
        .misaligned (alignMisaligned),
        .illegal    (alignIllegal)
    );

    assign access     = exValid && (exMemRead || exMemWrite);
    assign inReq      = (stateReg == LSU_REQ);
    assign alignFault = alignMisaligned || alignIllegal;
    assign idleFault  = !inReq && access && alignFault;
    assign startReq   = !inReq && access && !alignFault;
    assign ackHit     = inReq && memAck;
    assign timeoutHit = TIMEOUT_EN && inReq && !memAck && (cntReg == TIMEOUT_LAST);

    assign wbALUOutput = exALUOutput;
    assign wbWriteDir  = exWriteDir;
    assign wbMemToReg  = exMemToReg;

    always_comb begin
        stall        = startReq || (inReq && !memAck && !timeoutHit);
        // Gated by rst so the fault line is quiet while reset is held even
        // if EX/MEM happens to present a bad access.
        memFault     = (idleFault || timeoutHit) && !rst;
        wbRegWrite   = exRegWrite && exValid && !(idleFault || timeoutHit);
        // memWe still holds the in-flight access type during the ack cycle
        wbDataOutput = (ackHit && !memWe) ? alignLoad : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= LSU_IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memBe    <= 4'd0;
            memAddr  <= 32'd0;
            memWdata <= 32'd0;
            cntReg   <= '0;
        end else begin
            case (stateReg)
                LSU_IDLE: begin
                    if (startReq) begin
                        memAddr  <= {exALUOutput[31:2], 2'b00};
                        memBe    <= alignBe;
                        memWdata <= alignWdata;
                        memWe    <= exMemWrite;
                        memReq   <= 1'b1;
                        cntReg   <= '0;
                        stateReg <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (memAck || timeoutHit) begin
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        cntReg   <= '0;
                        stateReg <= LSU_IDLE;
                    end else if (cntReg != '1) begin
                        // Saturate so a disabled watchdog never wraps
                        cntReg <= cntReg + 1'b1;
                    end
                end
                default: stateReg <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic [31:0] exALUOutput;
    logic [31:0] exStoreData;
    logic        exMemRead;
    logic        exMemWrite;
    logic [2:0]  exFunct3;
    logic [4:0]  exWriteDir;
    logic        exRegWrite;
    logic        exMemToReg;
    logic [31:0] wbALUOutput;
    logic [31:0] wbDataOutput;
    logic [4:0]  wbWriteDir;
    logic        wbRegWrite;
    logic        wbMemToReg;
    logic        stall;
    logic        memFault;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic        memAck;
    logic [31:0] memRdata;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .exValid(exValid), .exALUOutput(exALUOutput), .exStoreData(exStoreData),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exFunct3(exFunct3),
        .exWriteDir(exWriteDir), .exRegWrite(exRegWrite), .exMemToReg(exMemToReg),
        .wbALUOutput(wbALUOutput), .wbDataOutput(wbDataOutput), .wbWriteDir(wbWriteDir),
        .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg), .stall(stall),
        .memFault(memFault), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memBe(memBe), .memAck(memAck), .memRdata(memRdata)
    );

    typedef struct {
        int          stallCycles;
        int          faultCycles;
        logic        finished;
        logic        finalFault;
        logic [31:0] dataOut;
        logic        regWr;
        logic [4:0]  dir;
        logic [4:0]  expDir;
        logic [31:0] aluOut;
        logic        memToReg;
        logic        reqSeen;
        logic [31:0] busAddr;
        logic [3:0]  busBe;
        logic [31:0] busWdata;
        logic        busWe;
        logic        busStable;
        logic        postReq;
        logic        postFault;
    } obs_t;

    // ---------------- reference model (size arithmetic) ----------------
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit modelFault(input logic [31:0] addr, input logic [2:0] f3);
        int sz = sizeOf(f3);
        if (sz == 0) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [31:0] addr, input logic [2:0] f3);
        int sz  = sizeOf(f3);
        int off = int'(addr % 4);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] sd, input logic [2:0] f3);
        logic [31:0] r;
        int sz = sizeOf(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] f3,
                                              input logic [31:0] rdata);
        int     sz  = sizeOf(f3);
        int     off = int'(addr % 4);
        longint v;
        v = (longint'(rdata) >> (8 * off)) & ((64'sd1 <<< (8 * sz)) - 1);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'sd1 <<< (8 * sz - 1)))
            v = v - (64'sd1 <<< (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- stimulus driver: one memory transaction ----------------
    // waits < 0 means memAck is never given.
    task automatic do_access(input logic [31:0] addr, input logic [2:0] f3, input logic isStore,
                             input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                             input logic regWr, output obs_t o);
        o = '{default: '0};
        o.busStable = 1'b1;
        @(posedge clk); #1;
        exValid     = 1'b1;
        exALUOutput = addr;
        exStoreData = sd;
        exMemRead   = !isStore;
        exMemWrite  = isStore;
        exFunct3    = f3;
        exWriteDir  = 5'($urandom);
        exRegWrite  = regWr;
        exMemToReg  = !isStore;
        memAck      = 1'b0;
        memRdata    = rdata;
        o.expDir    = exWriteDir;
        for (int k = 0; k < 40; k++) begin
            if (k >= 1) memAck = (waits >= 0) && (k == waits + 1);
            @(negedge clk);
            if (memFault) o.faultCycles++;
            if (memReq) o.reqSeen = 1'b1;
            if (k == 1) begin
                o.busAddr  = memAddr;
                o.busBe    = memBe;
                o.busWdata = memWdata;
                o.busWe    = memWe;
            end else if (k > 1) begin
                if (memAddr !== o.busAddr || memBe !== o.busBe || memWdata !== o.busWdata
                    || memWe !== o.busWe || memReq !== 1'b1) o.busStable = 1'b0;
            end
            if (stall) begin
                o.stallCycles++;
            end else begin
                o.finished   = 1'b1;
                o.finalFault = memFault;
                o.dataOut    = wbDataOutput;
                o.regWr      = wbRegWrite;
                o.dir        = wbWriteDir;
                o.aluOut     = wbALUOutput;
                o.memToReg   = wbMemToReg;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        exValid    = 1'b0;
        exMemRead  = 1'b0;
        exMemWrite = 1'b0;
        memAck     = 1'b0;
        @(negedge clk);
        o.postReq   = memReq;
        o.postFault = memFault;
        $display("txn addr=%h f3=%0d store=%0b waits=%0d stall=%0d fault=%0d data=%h be=%b wdata=%h",
                 addr, f3, isStore, waits, o.stallCycles, o.faultCycles, o.dataOut, o.busBe, o.busWdata);
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst = 1'b1;
        exValid = 1'b0; exALUOutput = '0; exStoreData = '0; exMemRead = 1'b0; exMemWrite = 1'b0;
        exFunct3 = '0; exWriteDir = '0; exRegWrite = 1'b0; exMemToReg = 1'b0;
        memAck = 1'b0; memRdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (memReq !== 1'b0) $display("FAIL rst_memReq got %b exp 0", memReq); else passes++;
        checks++; if (memWe !== 1'b0) $display("FAIL rst_memWe got %b exp 0", memWe); else passes++;
        checks++; if (memBe !== 4'd0) $display("FAIL rst_memBe got %b exp 0000", memBe); else passes++;
        checks++; if (memAddr !== 32'd0) $display("FAIL rst_memAddr got %h exp 0", memAddr); else passes++;
        checks++; if (memWdata !== 32'd0) $display("FAIL rst_memWdata got %h exp 0", memWdata); else passes++;
        checks++; if (memFault !== 1'b0) $display("FAIL rst_memFault got %b exp 0", memFault); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        obs_t o;
        do_access(32'h100, 3'd2, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1'b1, o);
        checks++; if (o.stallCycles !== 1) $display("FAIL lw_stall got %0d exp 1", o.stallCycles); else passes++;
        checks++; if (o.dataOut !== 32'hDEADBEEF) $display("FAIL lw_data got %h exp deadbeef", o.dataOut); else passes++;
        checks++; if (o.busAddr !== 32'h100) $display("FAIL lw_addr got %h exp 00000100", o.busAddr); else passes++;
        checks++; if (o.busWe !== 1'b0) $display("FAIL lw_we got %b exp 0", o.busWe); else passes++;
        checks++; if (o.busBe !== 4'b1111) $display("FAIL lw_be got %b exp 1111", o.busBe); else passes++;
        checks++; if (o.regWr !== 1'b1) $display("FAIL lw_regwr got %b exp 1", o.regWr); else passes++;
        checks++; if (o.postReq !== 1'b0) $display("FAIL lw_postreq got %b exp 0", o.postReq); else passes++;
    endtask

    task automatic test_byte_loads();
        obs_t o;
        do_access(32'h103, 3'd0, 1'b0, 32'h0, 32'h80FFFFFF, 0, 1'b1, o);
        checks++; if (o.dataOut !== 32'hFFFFFF80) $display("FAIL lb_data got %h exp ffffff80", o.dataOut); else passes++;
        checks++; if (o.busBe !== 4'b1000) $display("FAIL lb_be got %b exp 1000", o.busBe); else passes++;
        do_access(32'h103, 3'd4, 1'b0, 32'h0, 32'h80FFFFFF, 1, 1'b1, o);
        checks++; if (o.dataOut !== 32'h00000080) $display("FAIL lbu_data got %h exp 00000080", o.dataOut); else passes++;
        checks++; if (o.stallCycles !== 2) $display("FAIL lbu_stall got %0d exp 2", o.stallCycles); else passes++;
    endtask

    task automatic test_store_half();
        obs_t o;
        do_access(32'h102, 3'd1, 1'b1, 32'h1234ABCD, 32'h0, 3, 1'b0, o);
        checks++; if (o.busBe !== 4'b1100) $display("FAIL sh_be got %b exp 1100", o.busBe); else passes++;
        checks++; if (o.busWdata !== 32'hABCDABCD) $display("FAIL sh_wdata got %h exp abcdabcd", o.busWdata); else passes++;
        checks++; if (o.busWe !== 1'b1) $display("FAIL sh_we got %b exp 1", o.busWe); else passes++;
        checks++; if (o.busAddr !== 32'h100) $display("FAIL sh_addr got %h exp 00000100", o.busAddr); else passes++;
        checks++; if (o.stallCycles !== 4) $display("FAIL sh_stall got %0d exp 4", o.stallCycles); else passes++;
        checks++; if (o.busStable !== 1'b1) $display("FAIL sh_stable got %b exp 1", o.busStable); else passes++;
        checks++; if (o.dataOut !== 32'd0) $display("FAIL sh_data got %h exp 0", o.dataOut); else passes++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_access(32'h101, 3'd2, 1'b0, 32'h0, 32'h55AA55AA, 0, 1'b1, o);
        checks++; if (o.stallCycles !== 0) $display("FAIL mis_stall got %0d exp 0", o.stallCycles); else passes++;
        checks++; if (o.faultCycles !== 1) $display("FAIL mis_fault got %0d exp 1", o.faultCycles); else passes++;
        checks++; if (o.regWr !== 1'b0) $display("FAIL mis_regwr got %b exp 0", o.regWr); else passes++;
        checks++; if ((o.reqSeen | o.postReq) !== 1'b0) $display("FAIL mis_req got %b exp 0", o.reqSeen | o.postReq); else passes++;
        checks++; if (o.postFault !== 1'b0) $display("FAIL mis_postfault got %b exp 0", o.postFault); else passes++;
        do_access(32'h200, 3'd6, 1'b0, 32'h0, 32'h0, 0, 1'b1, o);
        checks++; if (o.faultCycles !== 1) $display("FAIL ill_fault got %0d exp 1", o.faultCycles); else passes++;
        checks++; if (o.postReq !== 1'b0) $display("FAIL ill_req got %b exp 0", o.postReq); else passes++;
    endtask

    task automatic test_timeout();
        obs_t o;
        do_access(32'h200, 3'd2, 1'b0, 32'h0, 32'h0, -1, 1'b1, o);
        checks++; if (o.finished !== 1'b1) $display("FAIL to_finish got %b exp 1", o.finished); else passes++;
        checks++; if (o.stallCycles !== TO) $display("FAIL to_stall got %0d exp %0d", o.stallCycles, TO); else passes++;
        checks++; if (o.finalFault !== 1'b1) $display("FAIL to_fault got %b exp 1", o.finalFault); else passes++;
        checks++; if (o.faultCycles !== 1) $display("FAIL to_faultcnt got %0d exp 1", o.faultCycles); else passes++;
        checks++; if (o.regWr !== 1'b0) $display("FAIL to_regwr got %b exp 0", o.regWr); else passes++;
        checks++; if (o.postReq !== 1'b0) $display("FAIL to_postreq got %b exp 0", o.postReq); else passes++;
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        exValid = 1'b1; exALUOutput = 32'h300; exMemRead = 1'b1; exMemWrite = 1'b0;
        exFunct3 = 3'd2; exRegWrite = 1'b1; memAck = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (memReq !== 1'b1) $display("FAIL rmr_pre_req got %b exp 1", memReq); else passes++;
        #2;
        rst = 1'b1;
        exValid = 1'b0; exMemRead = 1'b0;
        #1;
        checks++; if (memReq !== 1'b0) $display("FAIL rmr_req got %b exp 0", memReq); else passes++;
        checks++; if (memWe !== 1'b0 || memBe !== 4'd0) $display("FAIL rmr_bus got we=%b be=%b exp 0/0000", memWe, memBe); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        memAck = 1'b1;
        memRdata = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1'b0 || stall !== 1'b0 || memFault !== 1'b0 || wbDataOutput !== 32'd0)
                $display("FAIL rmr_stray_ack got req=%b stall=%b fault=%b data=%h exp 0/0/0/0",
                         memReq, stall, memFault, wbDataOutput);
            else passes++;
        end
        @(posedge clk); #1;
        memAck = 1'b0;
        $display("txn reset-mid-request addr=00000300");
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] bad   [3] = '{3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] addr, sd, rdata;
            logic        isStore, regWr, expFault;
            int          waits, sz;
            f3 = ($urandom_range(0, 7) == 0) ? bad[$urandom_range(0, 2)] : legal[$urandom_range(0, 4)];
            addr    = $urandom;
            sz      = sizeOf(f3);
            if (sz != 0 && $urandom_range(0, 2) != 0) addr = addr - (addr % sz);
            sd      = $urandom;
            rdata   = $urandom;
            isStore = 1'($urandom_range(0, 1));
            regWr   = 1'($urandom_range(0, 1));
            waits   = $urandom_range(0, TO - 1);
            expFault = modelFault(addr, f3);
            do_access(addr, f3, isStore, sd, rdata, waits, regWr, o);
            checks++; if (o.aluOut !== addr || o.dir !== o.expDir || o.memToReg !== !isStore)
                $display("FAIL rnd_pass n=%0d got alu=%h dir=%0d m2r=%b exp %h/%0d/%b",
                         n, o.aluOut, o.dir, o.memToReg, addr, o.expDir, !isStore);
            else passes++;
            if (expFault) begin
                checks++; if (o.faultCycles !== 1 || o.stallCycles !== 0 || o.regWr !== 1'b0 || o.postReq !== 1'b0)
                    $display("FAIL rnd_fault n=%0d got fault=%0d stall=%0d regwr=%b req=%b exp 1/0/0/0",
                             n, o.faultCycles, o.stallCycles, o.regWr, o.postReq);
                else passes++;
            end else begin
                checks++; if (o.faultCycles !== 0 || o.stallCycles !== waits + 1 || o.regWr !== regWr)
                    $display("FAIL rnd_flow n=%0d got fault=%0d stall=%0d regwr=%b exp 0/%0d/%b",
                             n, o.faultCycles, o.stallCycles, o.regWr, waits + 1, regWr);
                else passes++;
                checks++; if (o.busAddr !== (addr & ~32'd3) || o.busWe !== isStore || o.busBe !== modelBe(addr, f3))
                    $display("FAIL rnd_bus n=%0d got addr=%h we=%b be=%b exp %h/%b/%b",
                             n, o.busAddr, o.busWe, o.busBe, addr & ~32'd3, isStore, modelBe(addr, f3));
                else passes++;
                if (isStore) begin
                    checks++; if (o.busWdata !== modelWdata(sd, f3) || o.dataOut !== 32'd0)
                        $display("FAIL rnd_store n=%0d got wdata=%h data=%h exp %h/0",
                                 n, o.busWdata, o.dataOut, modelWdata(sd, f3));
                    else passes++;
                end else begin
                    checks++; if (o.dataOut !== modelLoad(addr, f3, rdata))
                        $display("FAIL rnd_load n=%0d got %h exp %h", n, o.dataOut, modelLoad(addr, f3, rdata));
                    else passes++;
                end
                checks++; if (o.busStable !== 1'b1 || o.postReq !== 1'b0)
                    $display("FAIL rnd_hold n=%0d got stable=%b postreq=%b exp 1/0", n, o.busStable, o.postReq);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_byte_loads();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
